// File: rtl/mips16_pkg.sv
// -----------------------------------------------------------------------------
// mips16_pkg
//   Shared constants and types for the 16-bit pipelined MIPS front end.
//   Contents:
//     PC_W / INSTR_W          datapath widths
//     RESET_PC_DEFAULT        PC loaded on reset
//     NOP_INSTR               bubble word injected on flush/boot/halt
//     HALT_OPCODE             opcode value that halts fetch
//     OPC_MSB / OPC_LSB       opcode field slice within an instruction
//     fetch_state_e           fetch FSM encoding (BOOT/RUN/HALT)
// -----------------------------------------------------------------------------
package mips16_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 16'h0000;
    localparam logic [3:0]         HALT_OPCODE      = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_perf_counters.sv
// -----------------------------------------------------------------------------
// if_perf_counters
//   Three 16-bit saturating event counters for the fetch stage. Each counter
//   increments by one on every clock where its strobe is high and sticks at
//   16'hFFFF. Synchronous active-high reset clears all three.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     fetch_ev          1 = normal (or halt-detect) fetch this cycle
//     stall_ev          1 = stalled RUN cycle
//     redirect_ev       1 = redirect taken this cycle
//     fetch_cnt         fetch event count
//     stall_cnt         stall event count
//     redirect_cnt      redirect event count
// -----------------------------------------------------------------------------
module if_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_ev,
    input  logic        stall_ev,
    input  logic        redirect_ev,
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt    <= 16'h0000;
            stall_cnt    <= 16'h0000;
            redirect_cnt <= 16'h0000;
        end else begin
            if (fetch_ev && (fetch_cnt != 16'hFFFF))
                fetch_cnt <= fetch_cnt + 16'd1;
            if (stall_ev && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (redirect_ev && (redirect_cnt != 16'hFFFF))
                redirect_cnt <= redirect_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 16-bit pipelined MIPS. Owns the PC, drives
//   the async-read instruction memory and feeds the IF/ID register.
//   Optional feature macro: IF_PERF_CNT_EN (adds fetch/stall/redirect counters).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     stall             hazard hold: freeze PC, IF/ID not loaded
//     redirect_valid    taken branch/jump from ID; wins over stall
//     redirect_target   new PC (bit0 forced to 0)
//     imem_addr         instruction memory address (= pc)
//     imem_rdata        instruction memory data, combinational from imem_addr
//     instruction       to IF/ID instruction
//     pc_plus_2         to IF/ID pc_plus_2 (pc+2, wraps at 16 bits)
//     if_id_en          to IF/ID load enable
//     halted            1 while in HALT
//     fetch_cnt, stall_cnt, redirect_cnt  (IF_PERF_CNT_EN only)
//   Handshake: there is no valid/ready pair here; if_id_en is the only flow
//   control, and it is low only on a stalled RUN cycle.
// -----------------------------------------------------------------------------
module if_fetch_stage
    import mips16_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [3:0]  HALT_OPC    = HALT_OPCODE,
    parameter logic [15:0] NOP_WORD    = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instruction,
    output logic [15:0] pc_plus_2,
    output logic        if_id_en,
`ifdef IF_PERF_CNT_EN
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt,
`endif
    output logic        halted
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic         is_halt_op;

    assign is_halt_op = (imem_rdata[OPC_MSB:OPC_LSB] == HALT_OPC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instruction = NOP_WORD;
        if_id_en    = 1'b1;
        case (state_q)
            FS_BOOT: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (redirect_valid) begin
                    // The word at the old PC is wrong-path: send a bubble instead.
                    pc_d = redirect_target & ~16'h0001;
                end else if (stall) begin
                    if_id_en    = 1'b0;
                    instruction = imem_rdata;
                end else if (is_halt_op) begin
                    // The halt word itself still goes down the pipe once.
                    instruction = imem_rdata;
                    state_d     = FS_HALT;
                end else begin
                    instruction = imem_rdata;
                    pc_d        = pc_q + 16'd2;
                end
            end
            FS_HALT: begin
                // Sticky until reset; keep draining bubbles.
            end
            default: begin
                state_d = FS_BOOT;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc_plus_2 = pc_q + 16'd2;
    assign halted    = (state_q == FS_HALT);

`ifdef IF_PERF_CNT_EN
    logic ev_fetch, ev_stall, ev_redirect;
    logic in_run;

    assign in_run      = (state_q == FS_RUN);
    assign ev_redirect = in_run && redirect_valid;
    assign ev_stall    = in_run && !redirect_valid && stall;
    assign ev_fetch    = in_run && !redirect_valid && !stall;

    if_perf_counters u_perf (
        .clk          (clk),
        .rst          (rst),
        .fetch_ev     (ev_fetch),
        .stall_ev     (ev_stall),
        .redirect_ev  (ev_redirect),
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
    );
`endif

endmodule
